fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
//   XLEN_DEF      default address / PC width
//   RESET_PC_DEF  default PC after reset
//   instr_t       32-bit instruction word
//   fetch_entry_t fetch-queue entry {pc, instr}
//   fetch_state_t fetch FSM states {FETCH, FLUSH}
package fetch_pkg;

    localparam int                    XLEN_DEF     = 32;
    localparam logic [XLEN_DEF-1:0]   RESET_PC_DEF = 32'h0000_0000;

    typedef logic [31:0] instr_t;

    // pc is carried at the package width; the top converts to/from XLEN.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        instr_t              instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t between the IMEM response path and decode.
//   clk, reset   clock / synchronous active-high reset
//   flush        empties the queue this edge (wins over push and pop)
//   push         write push_data (ignored when full)
//   pop          retire the head (ignored when empty)
//   head         head entry, forced to zero while empty
//   full, empty  occupancy flags
//   count        number of valid entries (0..DEPTH)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Zero while empty so decode sees clean 0s after reset/flush.
    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential IMEM requests, tags in-order
// responses with their PC, buffers them in fetch_queue and hands them to
// decode. Redirects flush the queue and drop responses still in flight.
//   clk, reset                 clock / synchronous active-high reset
//   redirect_valid/_pc         branch/jump redirect
//   imem_req_valid/_addr/_ready  fetch request handshake (byte address)
//   imem_rsp_valid/_data       in-order IMEM response
//   dec_valid/_ready/_pc/_instr  queue head towards decode
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched (pops) and
// perf_flushes (redirects) 32-bit wrapping counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     dec_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushes
`endif
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic            run;           // low for one cycle after reset
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;        // PC of oldest outstanding request
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   out_nxt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occ;
    logic [CW:0]     credit_sum;
    logic            credit_ok;
    logic            req_acc;
    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign req_acc = imem_req_valid && imem_req_ready;
    // Every response retires one outstanding request, dropped or not; an
    // acceptance in a redirect cycle still counts and is dropped later.
    assign out_nxt = outstanding + CW'(req_acc) - CW'(imem_rsp_valid);

    // Queue slots are reserved for everything in flight, so a response can
    // always be pushed without back-pressure toward IMEM.
    assign credit_sum = {1'b0, occ} + {1'b0, outstanding};
    assign credit_ok  = !q_full && (credit_sum < DEPTH_L);

    // Redirect wins over a coincident response or pop.
    assign push = imem_rsp_valid && (state == FETCH) && !redirect_valid;
    assign pop  = !q_empty && dec_ready && !redirect_valid;

    assign push_data.pc    = XLEN_DEF'(rsp_pc);
    assign push_data.instr = imem_rsp_data;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = (out_nxt != '0) ? FLUSH : FETCH;
        else if (state == FLUSH && imem_rsp_valid && drop_cnt == CW'(1))
            state_nxt = FETCH;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_req_valid = run && (state == FETCH) && credit_ok;
    end

    // ---------------- PC / counter datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= out_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop_cnt <= out_nxt;
            end else begin
                if (req_acc) fetch_pc <= fetch_pc + XLEN'(4);
                if (imem_rsp_valid) begin
                    if (state == FLUSH) drop_cnt <= drop_cnt - CW'(1);
                    else                rsp_pc   <= rsp_pc + XLEN'(4);
                end
            end
        end
    end

    assign imem_req_addr = fetch_pc;

    fetch_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (occ)
    );

    assign dec_valid = !q_empty;
    assign dec_pc    = XLEN'(head.pc);
    assign dec_instr = head.instr;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (pop)            perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushes   (perf_flushes)
`endif
    );

    function automatic logic [31:0] instr_of(logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        dr;
        logic        qv;
        logic [31:0] qa;
        logic        dv;
        logic [31:0] dpc;
        logic [31:0] dins;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic redir, logic [31:0] rpc, logic rdy, logic rv,
                                logic [31:0] rd, logic dr, logic qv, logic [31:0] qa,
                                logic dv, logic [31:0] dpc, logic [31:0] dins);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.dr = dr;
        v.qv = qv; v.qa = qa; v.dv = dv; v.dpc = dpc; v.dins = dins;
        return v;
    endfunction

    // ---------------- IMEM / decode model state ----------------
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];
    logic        pend_v;
    logic [31:0] pend_a;
    int          occ_m;
    int          out_m;
    int          pops_m;
    logic        wrap_seen;

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pend_v = 1'b0;
        pend_a = '0;
        occ_m = 0;
        out_m = 0;
        pops_m = 0;
        wrap_seen = 1'b0;
        exp_q.delete();
        model_pc = 32'h0;
    endtask

    // rdy_mode: 0 = always ready, 1 = random, 2 = never ready.
    // dec_ready is held low for the first dr_hold cycles.
    task automatic model_run(int n, int rdy_mode, int dr_hold, bit gap_chk);
        logic        prev_qv, prev_acc, prev_stall, acc, popped, rsp_now;
        logic [31:0] prev_qa, prev_dpc, prev_dins, acc_pc;
        prev_qv = 1'b0; prev_acc = 1'b0; prev_stall = 1'b0;
        prev_qa = '0; prev_dpc = '0; prev_dins = '0;
        for (int c = 0; c < n; c++) begin
            imem_rsp_valid = pend_v;
            imem_rsp_data  = pend_v ? instr_of(pend_a) : 32'h0;
            imem_req_ready = (rdy_mode == 0) ? 1'b1 :
                             (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            dec_ready      = (c >= dr_hold);
            #2;
            if (prev_qv && !prev_acc) begin
                check("req_valid_hold", 32'(imem_req_valid), 32'd1);
                check("req_addr_hold", imem_req_addr, prev_qa);
            end
            if (prev_stall) begin
                check("dec_pc_hold", dec_pc, prev_dpc);
                check("dec_instr_hold", dec_instr, prev_dins);
            end
            if (imem_req_valid) begin
                check("req_addr", imem_req_addr, model_pc);
                check("credit", 32'((occ_m + out_m) < DEPTH), 32'd1);
            end
            popped = dec_valid && dec_ready;
            if (popped) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", dec_pc, 32'hFFFF_FFFF);
                end else begin
                    check("dec_pc", dec_pc, exp_q[0]);
                    check("dec_instr", dec_instr, instr_of(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                pops_m++;
            end
            if (gap_chk && c >= 3) check("no_gap", 32'(dec_valid), 32'd1);
            acc = imem_req_valid && imem_req_ready;
            acc_pc = model_pc;
            if (acc) begin
                exp_q.push_back(model_pc);
                if (model_pc == 32'h0) wrap_seen = 1'b1;
                model_pc = model_pc + 32'd4;
            end
            rsp_now    = pend_v;
            prev_qv    = imem_req_valid;
            prev_acc   = acc;
            prev_qa    = imem_req_addr;
            prev_stall = dec_valid && !dec_ready;
            prev_dpc   = dec_pc;
            prev_dins  = dec_instr;
            @(posedge clk);
            #1;
            out_m = out_m + (acc ? 1 : 0) - (rsp_now ? 1 : 0);
            occ_m = occ_m + (rsp_now ? 1 : 0) - (popped ? 1 : 0);
            pend_v = acc;
            pend_a = acc_pc;
        end
    endtask

    initial begin
        // Table: inputs applied for one cycle, outputs expected in that cycle.
        //            redir rpc          rdy rv  rd                 dr   qv  qa           dv  dpc          dins
        tbl[0]  = mk(0, 32'h0,   1, 0, 32'h0,            0,   0, 32'h000,   0, 32'h0,   32'h0);
        tbl[1]  = mk(0, 32'h0,   1, 0, 32'h0,            1,   1, 32'h000,   0, 32'h0,   32'h0);
        tbl[2]  = mk(0, 32'h0,   1, 1, instr_of(32'h0),  1,   1, 32'h004,   0, 32'h0,   32'h0);
        tbl[3]  = mk(0, 32'h0,   1, 1, instr_of(32'h4),  1,   1, 32'h008,   1, 32'h0,   instr_of(32'h0));
        tbl[4]  = mk(0, 32'h0,   0, 1, instr_of(32'h8),  0,   1, 32'h00C,   1, 32'h4,   instr_of(32'h4));
        tbl[5]  = mk(0, 32'h0,   1, 0, 32'h0,            0,   1, 32'h00C,   1, 32'h4,   instr_of(32'h4));
        tbl[6]  = mk(0, 32'h0,   1, 0, 32'h0,            0,   1, 32'h010,   1, 32'h4,   instr_of(32'h4));
        tbl[7]  = mk(0, 32'h0,   1, 1, instr_of(32'hC),  0,   0, 32'h014,   1, 32'h4,   instr_of(32'h4));
        // redirect coincident with a response and a pop
        tbl[8]  = mk(1, 32'h100, 1, 1, instr_of(32'h10), 1,   0, 32'h014,   1, 32'h4,   instr_of(32'h4));
        tbl[9]  = mk(0, 32'h0,   1, 0, 32'h0,            1,   1, 32'h100,   0, 32'h0,   32'h0);
        tbl[10] = mk(0, 32'h0,   1, 1, instr_of(32'h100),1,   1, 32'h104,   0, 32'h0,   32'h0);
        tbl[11] = mk(0, 32'h0,   1, 0, 32'h0,            0,   1, 32'h108,   1, 32'h100, instr_of(32'h100));
        // redirect coincident with acceptance: 3 responses to drop
        tbl[12] = mk(1, 32'h200, 1, 0, 32'h0,            1,   1, 32'h10C,   1, 32'h100, instr_of(32'h100));
        tbl[13] = mk(0, 32'h0,   1, 1, 32'hDEAD_BEEF,    1,   0, 32'h200,   0, 32'h0,   32'h0);
        tbl[14] = mk(0, 32'h0,   1, 1, 32'hDEAD_BEEF,    1,   0, 32'h200,   0, 32'h0,   32'h0);
        tbl[15] = mk(0, 32'h0,   1, 1, 32'hDEAD_BEEF,    1,   0, 32'h200,   0, 32'h0,   32'h0);
        tbl[16] = mk(0, 32'h0,   1, 0, 32'h0,            1,   1, 32'h200,   0, 32'h0,   32'h0);
        tbl[17] = mk(0, 32'h0,   0, 1, instr_of(32'h200),1,   1, 32'h204,   0, 32'h0,   32'h0);
        tbl[18] = mk(0, 32'h0,   0, 0, 32'h0,            1,   1, 32'h204,   1, 32'h200, instr_of(32'h200));
        tbl[19] = mk(0, 32'h0,   0, 0, 32'h0,            1,   1, 32'h204,   0, 32'h0,   32'h0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rv;
            imem_rsp_data  = tbl[i].rd;
            dec_ready      = tbl[i].dr;
            #2;
            check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].qv));
            check($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].qa);
            check($sformatf("v%0d_dec_valid", i), 32'(dec_valid), 32'(tbl[i].dv));
            check($sformatf("v%0d_dec_pc", i), dec_pc, tbl[i].dpc);
            check($sformatf("v%0d_dec_instr", i), dec_instr, tbl[i].dins);
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;

        // Steady state: 1-cycle IMEM, always ready, no bubbles.
        do_reset();
        model_run(30, 0, 0, 1'b1);
        model_run(4, 2, 0, 1'b0);
        check("steady_drained", 32'(exp_q.size()), 32'd0);
        check("steady_pops", 32'(pops_m), 32'd29);

        // Decode stalled 11 cycles: queue fills to DEPTH, requests stop.
        do_reset();
        model_run(11, 0, 11, 1'b0);
        check("stall_occ", 32'(occ_m), 32'(DEPTH));
        check("stall_no_req", 32'(imem_req_valid), 32'd0);
        check("stall_dec_valid", 32'(dec_valid), 32'd1);
        model_run(15, 0, 0, 1'b0);
        model_run(4, 2, 0, 1'b0);
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Random request back-pressure across the address wrap.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        model_pc = 32'hFFFF_FFF8;
        model_run(40, 1, 0, 1'b0);
        model_run(4, 2, 0, 1'b0);
        check("wrap_seen", 32'(wrap_seen), 32'd1);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        check("perf_fetched_reset", perf_fetched, 32'd0);
        check("perf_flushes_reset", perf_flushes, 32'd0);
        model_run(21, 0, 0, 1'b0);
        model_run(4, 2, 0, 1'b0);
        check("perf_fetched_20", perf_fetched, 32'd20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("perf_flushes_3", perf_flushes, 32'd3);
        check("perf_fetched_hold", perf_fetched, 32'd20);
        do_reset();
        @(posedge clk);
        #1;
        check("perf_fetched_clr", perf_fetched, 32'd0);
        check("perf_flushes_clr", perf_flushes, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
